// File: rtl/rr_grant_arbiter8_pkg.sv
// Shared definitions for the 8-requester round-robin grant arbiter.
// Holds the FSM state encoding, requester count, index width and default hold limit.
// No logic; imported by the arbiter top and its decoder.
package rr_grant_arbiter8_pkg;

  localparam int NUM_REQ      = 8;
  localparam int ID_W         = 3;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_grant_arbiter8_onehot_dec3.sv
// 3-to-8 one-hot decoder with an enable gate.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: i_idx (index), i_en (gate), o_onehot (decoded select lines, all 0 when gated).
module rr_grant_arbiter8_onehot_dec3
  import rr_grant_arbiter8_pkg::*;
(
  input  logic [ID_W-1:0]    i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);

  assign o_onehot = i_en ? (NUM_REQ'(1) << i_idx) : '0;

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters via a one-hot select.
// Latency: req sampled on edge N drives gnt after edge N; one dead cycle between owners.
// Backpressure: the owner holds the grant while its req stays high; no preemption.
// Ports: clk, rst_n (async active-low), en (gates new grants only), req[7:0],
//        gnt[7:0] (one-hot), gnt_id[2:0] (current/last owner), gnt_vld, timeout (revoke pulse).
// Build option ARB_TIMEOUT_EN: bound each grant to HOLD_MAX cycles and pulse timeout on revoke.
module rr_grant_arbiter8
  import rr_grant_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               timeout
);

  arb_state_t      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_gnt_id;
  logic            r_gnt_vld;

`ifdef ARB_TIMEOUT_EN
  // r_cnt counts visible grant cycles minus one, so the limit edge sees HOLD_MAX-1.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
`endif

  // First requester after p, scanning p+1 .. p+8 with modulo-8 wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = p + ID_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= ID_W'(NUM_REQ - 1);
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (en && (req != '0)) begin
            r_gnt_id  <= rr_pick(req, r_ptr);
            r_gnt_vld <= 1'b1;
            r_state   <= GRANT;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        GRANT: begin
          // Normal release wins over a timeout on the same edge.
          if (!req[r_gnt_id]) begin
            r_gnt_vld <= 1'b0;
            r_ptr     <= r_gnt_id;
            r_state   <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == HOLD_LAST) begin
            r_gnt_vld <= 1'b0;
            r_ptr     <= r_gnt_id;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  // Hold-limit parameters only matter when timeouts are built in.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(HOLD_MAX), 32'(CNT_W)};
  assign timeout      = 1'b0;
`endif

  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;

  // Grant lines come only from registered state, so at most one is ever high.
  rr_grant_arbiter8_onehot_dec3 u_gnt_dec (
    .i_idx    (r_gnt_id),
    .i_en     (r_gnt_vld),
    .o_onehot (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Self-checking bench for rr_grant_arbiter8: directed scenarios plus random traffic.
// The driver updates a behavioural model per clock edge and queues expected outputs;
// a monitor on the falling edge pops and compares them.
module tb_rr_grant_arbiter8;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  rr_grant_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: owner, busy flag, cycles the grant has been visible, last owner.
  bit   m_vld;
  int   m_id;
  int   m_ptr;
  int   m_held;
  bit   m_to;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_id = 0; m_ptr = 7; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic [7:0] r);
    exp_t x;
    m_to = 1'b0;
    if (!m_vld) begin
      if (e && r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          if (!m_vld && r[(m_ptr + k) % 8]) begin
            m_id = (m_ptr + k) % 8; m_vld = 1'b1; m_held = 1;
          end
        end
      end
    end else if (!r[m_id]) begin
      m_vld = 1'b0; m_ptr = m_id;
    end else if (TO_EN && m_held >= HOLD) begin
      m_vld = 1'b0; m_ptr = m_id; m_to = 1'b1;
    end else begin
      m_held++;
    end
    x.gnt = m_vld ? 8'(1 << m_id) : 8'h00;
    x.id  = 3'(m_id);
    x.vld = m_vld;
    x.to  = m_to;
    sb.push_back(x);
  endtask

  task automatic step(input logic e, input logic [7:0] r);
    en = e; req = r;
    @(posedge clk);
    model_edge(e, r);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("gnt",     32'(gnt),     32'(x.gnt));
        chk("gnt_id",  32'(gnt_id),  32'(x.id));
        chk("gnt_vld", 32'(gnt_vld), 32'(x.vld));
        chk("timeout", 32'(timeout), 32'(x.to));
        chk("onehot",  32'($countones(gnt) <= 1), 32'd1);
      end
    end
  end

  initial begin
    bit saw_to;
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",     32'(gnt),     32'h00);
    chk("rst_gnt_id",  32'(gnt_id),  32'h0);
    chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    #1 rst_n = 1'b1;

    // Single request from reset: agent 0 granted after one edge.
    step(1'b1, 8'h01);
    chk("s1_gnt", 32'(gnt), 32'h01);

    // All requesting: owners rotate 0..7,0, each holding 3 cycles, dead cycle between.
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step(1'b1, 8'hFF);
      chk("s2_order", 32'(gnt_id), 32'(k % 8));
      step(1'b1, 8'hFF);
      step(1'b1, 8'hFF);
      step(1'b1, 8'hFF & ~8'(1 << (k % 8)));
      chk("s2_dead", 32'(gnt), 32'h00);
    end

    // Agent 2 releases, re-raises in the dead cycle alongside agent 0: wrap picks 0.
    step(1'b1, 8'h04);
    chk("s3_own2", 32'(gnt), 32'h04);
    step(1'b1, 8'h04);
    step(1'b1, 8'h01);
    step(1'b1, 8'h05);
    chk("s3_wrap", 32'(gnt), 32'h01);
    step(1'b1, 8'h00);

    // Enable gates new grants only.
    for (int k = 0; k < 5; k++) step(1'b0, 8'h10);
    chk("s4_en_off", 32'(gnt), 32'h00);
    step(1'b1, 8'h10);
    chk("s4_en_on", 32'(gnt), 32'h10);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h10);
    chk("s4_hold", 32'(gnt), 32'h10);
    step(1'b0, 8'h00);

    // Long hold: revoked after HOLD cycles when timeouts are built in, else unbounded.
    saw_to = 1'b0;
    step(1'b1, 8'h03);
    chk("s5_first", 32'(gnt), 32'h01);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 8'h03);
      if (timeout) saw_to = 1'b1;
    end
    chk("s5_timeout_seen", 32'(saw_to), 32'(TO_EN));
    chk("s5_final", 32'(gnt), TO_EN ? 32'h02 : 32'h01);
    step(1'b1, 8'h00);

    // Asynchronous reset in the middle of a grant.
    step(1'b1, 8'h08);
    step(1'b1, 8'h08);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_gnt",     32'(gnt),     32'h00);
    chk("s6_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("s6_timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'h81);
    chk("s6_after", 32'(gnt), 32'h01);
    step(1'b1, 8'h00);

    // Random traffic; the current owner tends to keep its request up.
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      if (m_vld && $urandom_range(0, 3) != 0) r[m_id] = 1'b1;
      step(1'($urandom_range(0, 3) != 0), r);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
